wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and scoreboard sitting in front of the register file write port; the producer end of the register-file write interface. It merges the in-order pipeline write-back with results returning from long-latency units (multiply/divide, slow loads) into the single regw/A3/WD write port. Out-of-order results are buffered in a small FIFO, and a per-register pending bitmask is kept so the hazard unit can stall readers of registers still awaiting a long-latency result.

## Interface
- DEPTH, 4, async-result FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- pw_en  in  1  pipeline write-back valid this cycle (cannot be back-pressured)
- pw_addr  in  5  pipeline destination register
- pw_data  in  32  pipeline write data
- aw_valid  in  1  long-latency result valid
- aw_addr  in  5  long-latency destination register
- aw_data  in  32  long-latency result data
- aw_ready  out  1  FIFO can accept; transfer when aw_valid && aw_ready
- iss_en  in  1  long-latency op issued this cycle
- iss_addr  in  5  its destination register
- regw  out  1  register-file write enable
- A3  out  5  register-file write address
- WD  out  32  register-file write data
- pending  out  32  bit r = 1 while register r awaits a long-latency result
- fifo_full  out  1  FIFO holds DEPTH entries; pipeline must insert a WB bubble

## Operation
- FIFO: DEPTH × {addr[4:0], data[31:0]}, read/write pointers wrap modulo DEPTH, count of clog2(DEPTH)+1 bits.
- Push when aw_valid && aw_ready. aw_ready = (count < DEPTH), from registered count only; a pop in the same cycle does not free a slot for that cycle's push.
- Port select (combinational, each cycle):
  - pw_en && pw_addr != 0 → regw=1, A3=pw_addr, WD=pw_data; FIFO not popped.
  - else if count != 0 → pop head; head addr != 0 gives regw=1, A3/WD = head; head addr 0 is popped with regw=0.
  - else regw=0, A3=0, WD=0.
- Writes to register 0 never assert regw (pipeline or FIFO).
- Simultaneous push and pop (count > 0, not full): both occur; count unchanged.
- Push into empty FIFO: entry is poppable the following cycle, not the same cycle (no FIFO bypass).
- Scoreboard, per register r (r ≠ 0):
  - set when iss_en && iss_addr == r;
  - clear when a FIFO pop writes r;
  - set and clear in the same cycle → stays set (new issue wins);
  - pipeline writes never change pending.
  - pending[0] is hard 0.
- Upstream contracts (not checked here): no pipeline write to a register with pending set; at most one outstanding long-latency op per register; pipeline inserts a WB bubble while fifo_full.

## Timing
- Reset (rst_n low, asynchronous): pointers and count 0, pending 0, aw_ready 1, fifo_full 0, regw/A3/WD forced to 0 regardless of pw_en.
- FIFO contents are not reset.
- Pipeline write latency: 0 cycles; regw/A3/WD are combinational from pw_*, and the register file commits at the same posedge.
- Async result latency: ≥1 cycle from accept to regw. With pipeline writes every cycle, a result is delayed until the first cycle with pw_en = 0 or pw_addr = 0.
- pending: registered; set is visible the cycle after iss_en; clear is visible the cycle after the regw pop.
- fifo_full: registered (count == DEPTH).
- Reset asserted mid-operation: buffered results are discarded and pending is cleared; the issuing side must also flush.

## Test plan
- Reset with pw_en=1, pw_addr=5 → regw=0, aw_ready=1, pending=0. After release, the same inputs → regw=1, A3=5, WD=pw_data in the same cycle.
- iss_en with iss_addr=8; 3 cycles later aw {8, 0xDEADBEEF}, pw_en=0 → pending[8]=1 from the next cycle; regw=1, A3=8, WD=0xDEADBEEF one cycle after accept; pending[8]=0 the following cycle.
- DEPTH=4: push 4 results to r1–r4 while pw_en=1 to r9 each cycle → fifo_full=1, aw_ready=0, 5th held; drop pw_en → pops r1, r2, r3, r4 in order, one per cycle; aw_ready returns the cycle after the first pop.
- aw to register 0 and pw to register 0 → regw stays 0; the FIFO entry is still consumed (count decrements).
- Same cycle: iss_en to r6 and pop writing r6 → pending[6] remains 1.
- Assert rst_n low with 3 entries buffered and pending=0x000000F0 → count=0 and pending=0 immediately; no stale write after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges pipeline write-back with buffered long-latency results
// into the single register-file write port and tracks per-register pending results.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pw_en,
  input  logic [4:0]  pw_addr,
  input  logic [31:0] pw_data,
  input  logic        aw_valid,
  input  logic [4:0]  aw_addr,
  input  logic [31:0] aw_data,
  output logic        aw_ready,
  input  logic        iss_en,
  input  logic [4:0]  iss_addr,
  output logic        regw,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic [31:0] pending,
  output logic        fifo_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [4:0]    fifoAddr_q [DEPTH];
  logic [31:0]   fifoData_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pending_q, pending_d;

  logic        push, pop, pwWrite;
  logic [4:0]  headAddr;
  logic [31:0] headData;
  logic [31:0] setMask, clearMask;

  assign headAddr  = fifoAddr_q[rdPtr_q];
  assign headData  = fifoData_q[rdPtr_q];
  assign aw_ready  = (count_q < FullCount);
  assign fifo_full = (count_q == FullCount);
  assign pending   = pending_q;

  // Pipeline write-back always wins; the FIFO drains only in bubble cycles.
  always_comb begin
    pwWrite = pw_en && (pw_addr != 5'd0);
    push    = aw_valid && aw_ready;
    pop     = !pwWrite && (count_q != '0);
    regw    = 1'b0;
    A3      = 5'd0;
    WD      = 32'd0;
    if (rst_n) begin
      if (pwWrite) begin
        regw = 1'b1;
        A3   = pw_addr;
        WD   = pw_data;
      end else if (pop && (headAddr != 5'd0)) begin
        regw = 1'b1;
        A3   = headAddr;
        WD   = headData;
      end
    end
  end

  always_comb begin
    wrPtr_d = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new issue to a register overrides a completion to the same register.
  always_comb begin
    clearMask = (pop && (headAddr != 5'd0)) ? (32'd1 << headAddr) : 32'd0;
    setMask   = iss_en ? (32'd1 << iss_addr) : 32'd0;
    pending_d = ((pending_q & ~clearMask) | setMask) & ~32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoAddr_q[wrPtr_q] <= aw_addr;
      fifoData_q[wrPtr_q] <= aw_data;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a vector table for the pipeline path plus
// hand-written sequences checked against a result queue and a pending-mask model.
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        pw_en;
  logic [4:0]  pw_addr;
  logic [31:0] pw_data;
  logic        aw_valid;
  logic [4:0]  aw_addr;
  logic [31:0] aw_data;
  logic        aw_ready;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        regw;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [31:0] pending;
  logic        fifo_full;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wbEntry_t;

  typedef struct {
    logic        pwEn;
    logic [4:0]  pwAddr;
    logic [31:0] pwData;
    logic        expRegw;
    logic [4:0]  expA3;
    logic [31:0] expWD;
  } vector_t;

  wbEntry_t    mQ[$];
  logic [31:0] mPending;
  logic        lastAccepted;
  int          checks;
  int          errors;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pw_en     (pw_en),
    .pw_addr   (pw_addr),
    .pw_data   (pw_data),
    .aw_valid  (aw_valid),
    .aw_addr   (aw_addr),
    .aw_data   (aw_data),
    .aw_ready  (aw_ready),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .regw      (regw),
    .A3        (A3),
    .WD        (WD),
    .pending   (pending),
    .fifo_full (fifo_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model at the edge.
  task automatic applyStimulus(input string tag);
    logic        pwWrite, expPop, expReady, expRegw;
    logic [4:0]  expA3;
    logic [31:0] expWD;
    wbEntry_t    head;
    @(negedge clk);
    pwWrite  = pw_en && (pw_addr != 5'd0);
    expPop   = !pwWrite && (mQ.size() != 0);
    expReady = (mQ.size() < DEPTH);
    expRegw  = 1'b0;
    expA3    = 5'd0;
    expWD    = 32'd0;
    head     = '{5'd0, 32'd0};
    if (pwWrite) begin
      expRegw = 1'b1;
      expA3   = pw_addr;
      expWD   = pw_data;
    end else if (expPop) begin
      head = mQ[0];
      if (head.addr != 5'd0) begin
        expRegw = 1'b1;
        expA3   = head.addr;
        expWD   = head.data;
      end
    end
    checkOutput({tag, " regw"}, 32'(regw), 32'(expRegw));
    checkOutput({tag, " A3"}, 32'(A3), 32'(expA3));
    checkOutput({tag, " WD"}, WD, expWD);
    checkOutput({tag, " aw_ready"}, 32'(aw_ready), 32'(expReady));
    checkOutput({tag, " fifo_full"}, 32'(fifo_full), 32'(mQ.size() == DEPTH));
    checkOutput({tag, " pending"}, pending, mPending);
    @(posedge clk);
    if (expPop) begin
      void'(mQ.pop_front());
      if (head.addr != 5'd0) mPending[head.addr] = 1'b0;
    end
    if (iss_en) mPending[iss_addr] = 1'b1;
    mPending[0] = 1'b0;
    lastAccepted = aw_valid && expReady;
    if (lastAccepted) mQ.push_back('{aw_addr, aw_data});
    #1;
  endtask

  initial begin
    vector_t vecs[5];
    checks       = 0;
    errors       = 0;
    mPending     = 32'd0;
    lastAccepted = 1'b0;
    rst_n    = 1'b0;
    pw_en    = 1'b1;
    pw_addr  = 5'd5;
    pw_data  = 32'h1234_5678;
    aw_valid = 1'b0;
    aw_addr  = 5'd0;
    aw_data  = 32'd0;
    iss_en   = 1'b0;
    iss_addr = 5'd0;

    #3;
    checkOutput("reset regw", 32'(regw), 32'd0);
    checkOutput("reset aw_ready", 32'(aw_ready), 32'd1);
    checkOutput("reset pending", pending, 32'd0);
    checkOutput("reset fifo_full", 32'(fifo_full), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 1'b1, 5'd5,  32'h1234_5678};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'd0};
    vecs[2] = '{1'b0, 5'd31, 32'h0000_AAAA, 1'b0, 5'd0,  32'd0};
    vecs[3] = '{1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd31, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  32'h0000_0000};
    for (int i = 0; i < 5; i++) begin
      pw_en   = vecs[i].pwEn;
      pw_addr = vecs[i].pwAddr;
      pw_data = vecs[i].pwData;
      @(negedge clk);
      checkOutput($sformatf("vec%0d regw", i), 32'(regw), 32'(vecs[i].expRegw));
      checkOutput($sformatf("vec%0d A3", i), 32'(A3), 32'(vecs[i].expA3));
      checkOutput($sformatf("vec%0d WD", i), WD, vecs[i].expWD);
      @(posedge clk);
      #1;
    end

    // Single long-latency op to r8.
    pw_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd8;
    applyStimulus("iss8");
    iss_en = 1'b0;
    applyStimulus("wait8a");
    applyStimulus("wait8b");
    aw_valid = 1'b1; aw_addr = 5'd8; aw_data = 32'hDEAD_BEEF;
    applyStimulus("aw8");
    aw_valid = 1'b0;
    applyStimulus("pop8");
    applyStimulus("clr8");

    // Fill the FIFO behind continuous pipeline writes, then drain.
    for (int r = 1; r <= 4; r++) begin
      iss_en = 1'b1; iss_addr = 5'(r);
      applyStimulus("issFill");
    end
    iss_en = 1'b0;
    pw_en = 1'b1; pw_addr = 5'd9;
    for (int r = 1; r <= 5; r++) begin
      pw_data  = 32'h9000_0000 + 32'(r);
      aw_valid = 1'b1; aw_addr = 5'(r); aw_data = 32'hA000_0000 + 32'(r);
      applyStimulus($sformatf("fill%0d", r));
    end
    pw_en = 1'b0;
    for (int c = 0; c < 7; c++) begin
      applyStimulus($sformatf("drain%0d", c));
      if (lastAccepted) aw_valid = 1'b0;
    end
    aw_valid = 1'b0;

    // Register-0 entry is consumed silently while pw targets r0.
    aw_valid = 1'b1; aw_addr = 5'd0; aw_data = 32'h1111_1111;
    applyStimulus("awR0");
    pw_en = 1'b1; pw_addr = 5'd0; pw_data = 32'h2222_2222;
    aw_addr = 5'd7; aw_data = 32'h7777_7777;
    applyStimulus("popR0");
    aw_valid = 1'b0; pw_en = 1'b0;
    applyStimulus("popR7");
    applyStimulus("idleR7");

    // Re-issue to r6 in the same cycle its previous result retires.
    iss_en = 1'b1; iss_addr = 5'd6;
    applyStimulus("iss6");
    iss_en = 1'b0;
    aw_valid = 1'b1; aw_addr = 5'd6; aw_data = 32'h6666_6666;
    applyStimulus("aw6");
    aw_valid = 1'b0; iss_en = 1'b1;
    applyStimulus("pop6iss6");
    iss_en = 1'b0;
    applyStimulus("hold6");
    aw_valid = 1'b1; aw_data = 32'h6666_6667;
    applyStimulus("aw6b");
    aw_valid = 1'b0;
    applyStimulus("pop6b");
    applyStimulus("clr6");

    // Asynchronous reset with buffered results and pending bits.
    for (int r = 4; r <= 7; r++) begin
      iss_en = 1'b1; iss_addr = 5'(r);
      applyStimulus("issRst");
    end
    iss_en = 1'b0;
    pw_en = 1'b1; pw_addr = 5'd9; pw_data = 32'h9999_9999;
    for (int r = 4; r <= 6; r++) begin
      aw_valid = 1'b1; aw_addr = 5'(r); aw_data = 32'hB000_0000 + 32'(r);
      applyStimulus("bufRst");
    end
    aw_valid = 1'b0;
    applyStimulus("holdRst");
    checkOutput("preRst pending", pending, 32'h0000_00F0);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst regw", 32'(regw), 32'd0);
    checkOutput("midRst pending", pending, 32'd0);
    checkOutput("midRst aw_ready", 32'(aw_ready), 32'd1);
    checkOutput("midRst fifo_full", 32'(fifo_full), 32'd0);
    mQ.delete();
    mPending = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pw_en = 1'b0;
    for (int c = 0; c < 4; c++) applyStimulus($sformatf("postRst%0d", c));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
